snake_head_motion: RTL and testbench

//  Producer of the snake head position, size and facing that the sprite renderer consumes
//  (snakeX_pos/snakeY_pos/snake_size/motionFlag). Converts keyboard keycodes into a

---
 rtl/snake_head_motion_if.sv | 22 ++
 rtl/snake_head_motion.sv | 166 ++++++++++++++++
 tb/tb_snake_head_motion.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/snake_head_motion_if.sv
// Bundle between the keyboard/VGA side and the snake head motion block.
// The master drives keycode and vs; the slave (motion block) drives the head state.
interface snake_head_motion_if;
    logic [7:0] keycode;
    logic       vs;
    logic [9:0] snakeX_pos;
    logic [9:0] snakeY_pos;
    logic [9:0] snake_size;
    logic [1:0] motionFlag;
    logic       step_pulse;
    logic       game_over;

    modport master (
        output keycode, vs,
        input  snakeX_pos, snakeY_pos, snake_size, motionFlag, step_pulse, game_over
    );

    modport slave (
        input  keycode, vs,
        output snakeX_pos, snakeY_pos, snake_size, motionFlag, step_pulse, game_over
    );
endinterface

// File: rtl/snake_head_motion.sv
// Snake head motion: turns keycodes into a committed facing and steps the head one grid
// cell every FRAMES_PER_STEP frames, entering a latched game-over state on a wall hit.
module snake_head_motion #(
    parameter int unsigned STEP            = 24,
    parameter int unsigned X_MIN           = 12,
    parameter int unsigned X_MAX           = 612,
    parameter int unsigned Y_MIN           = 12,
    parameter int unsigned Y_MAX           = 468,
    parameter int unsigned X_START         = 300,
    parameter int unsigned Y_START         = 228,
    parameter int unsigned FRAMES_PER_STEP = 8
) (
    input logic             Clk,
    input logic             Reset,
    snake_head_motion_if.slave bus
);
    localparam int unsigned CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);

    localparam logic [9:0] STEP_V  = 10'(STEP);
    localparam logic [9:0] W_LIM   = 10'(Y_MIN + STEP);
    localparam logic [9:0] S_LIM   = 10'(Y_MAX - STEP);
    localparam logic [9:0] A_LIM   = 10'(X_MIN + STEP);
    localparam logic [9:0] D_LIM   = 10'(X_MAX - STEP);
    localparam logic [9:0] X_RST   = 10'(X_START);
    localparam logic [9:0] Y_RST   = 10'(Y_START);

    localparam logic [1:0] DIR_W = 2'b00;
    localparam logic [1:0] DIR_A = 2'b01;
    localparam logic [1:0] DIR_S = 2'b10;
    localparam logic [1:0] DIR_D = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;

    state_t           state_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic [1:0]       motion_q;
    logic [1:0]       dir_next_q;
    logic [CNT_W-1:0] frame_cnt_q;
    logic             vs_d_q;
    logic             step_pulse_q;
    logic             game_over_q;

    logic             key_is_dir_c;
    logic [1:0]       key_dir_c;
    logic             key_restart_c;
    logic             frame_c;
    logic             reversal_c;
    logic             step_legal_c;
    logic [9:0]       x_tgt_c;
    logic [9:0]       y_tgt_c;

    // Keycode decode: WASD map to facings, space requests restart.
    always_comb begin
        key_is_dir_c = 1'b1;
        key_dir_c    = DIR_W;
        case (bus.keycode)
            8'h1A:   key_dir_c = DIR_W;
            8'h04:   key_dir_c = DIR_A;
            8'h16:   key_dir_c = DIR_S;
            8'h07:   key_dir_c = DIR_D;
            default: key_is_dir_c = 1'b0;
        endcase
    end

    assign key_restart_c = (bus.keycode == 8'h2C);
    assign frame_c       = bus.vs & ~vs_d_q;
    // Opposite facings share bit0 and differ in bit1; compared against the committed facing.
    assign reversal_c    = (key_dir_c[1] != motion_q[1]) && (key_dir_c[0] == motion_q[0]);

    // Bounds are tested on the current position so the 10-bit target never wraps.
    always_comb begin
        step_legal_c = 1'b0;
        x_tgt_c      = x_q;
        y_tgt_c      = y_q;
        case (dir_next_q)
            DIR_W: begin
                step_legal_c = (y_q >= W_LIM);
                y_tgt_c      = y_q - STEP_V;
            end
            DIR_A: begin
                step_legal_c = (x_q >= A_LIM);
                x_tgt_c      = x_q - STEP_V;
            end
            DIR_S: begin
                step_legal_c = (y_q <= S_LIM);
                y_tgt_c      = y_q + STEP_V;
            end
            DIR_D: begin
                step_legal_c = (x_q <= D_LIM);
                x_tgt_c      = x_q + STEP_V;
            end
            default: step_legal_c = 1'b0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            x_q          <= X_RST;
            y_q          <= Y_RST;
            motion_q     <= DIR_W;
            dir_next_q   <= DIR_W;
            frame_cnt_q  <= '0;
            vs_d_q       <= 1'b0;
            step_pulse_q <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            vs_d_q       <= bus.vs;
            step_pulse_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (key_is_dir_c) begin
                        state_q     <= RUN;
                        motion_q    <= key_dir_c;
                        dir_next_q  <= key_dir_c;
                        frame_cnt_q <= '0;
                    end
                end
                RUN: begin
                    if (key_is_dir_c && !reversal_c) begin
                        dir_next_q <= key_dir_c;
                    end
                    if (frame_c) begin
                        if (frame_cnt_q == CNT_LAST) begin
                            frame_cnt_q <= '0;
                            // Facing and position only ever change together.
                            if (step_legal_c) begin
                                x_q          <= x_tgt_c;
                                y_q          <= y_tgt_c;
                                motion_q     <= dir_next_q;
                                step_pulse_q <= 1'b1;
                            end else begin
                                state_q     <= DEAD;
                                game_over_q <= 1'b1;
                            end
                        end else begin
                            frame_cnt_q <= frame_cnt_q + CNT_W'(1);
                        end
                    end
                end
                DEAD: begin
                    if (key_restart_c) begin
                        state_q     <= IDLE;
                        x_q         <= X_RST;
                        y_q         <= Y_RST;
                        motion_q    <= DIR_W;
                        dir_next_q  <= DIR_W;
                        frame_cnt_q <= '0;
                        game_over_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.snakeX_pos = x_q;
    assign bus.snakeY_pos = y_q;
    assign bus.snake_size = 10'(STEP / 2);
    assign bus.motionFlag = motion_q;
    assign bus.step_pulse = step_pulse_q;
    assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_snake_head_motion.sv
// Directed and randomized checks of snake_head_motion against a grid-level reference model.
module tb_snake_head_motion;
    localparam int STEP = 24;
    localparam int XMIN = 12;
    localparam int XMAX = 612;
    localparam int YMIN = 12;
    localparam int YMAX = 468;
    localparam int XST  = 300;
    localparam int YST  = 228;
    localparam int FPS  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   pulse_cnt = 0;

    snake_head_motion_if bus();

    snake_head_motion dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: facing index 0=up 1=left 2=down 3=right as unit vectors.
    int dx[4] = '{0, -1, 0, 1};
    int dy[4] = '{-1, 0, 1, 0};
    int m_x, m_y, m_face, m_pend, m_frames;
    bit m_started, m_dead, m_vs_prev, m_pulse;

    function automatic int key_to_dir(input logic [7:0] k);
        case (k)
            8'h1A:   return 0;
            8'h04:   return 1;
            8'h16:   return 2;
            8'h07:   return 3;
            default: return -1;
        endcase
    endfunction

    function automatic bit is_reverse(input int a, input int b);
        return (dx[a] == -dx[b]) && (dy[a] == -dy[b]);
    endfunction

    task automatic model_restart();
        m_x = XST; m_y = YST; m_face = 0; m_pend = 0; m_frames = 0;
        m_started = 0; m_dead = 0;
    endtask

    task automatic model_edge(input logic [7:0] k, input logic v, input logic r);
        int d, nx, ny, use_dir;
        bit frame;
        if (r) begin
            model_restart();
            m_vs_prev = 0; m_pulse = 0;
            return;
        end
        frame = v && !m_vs_prev;
        m_vs_prev = v;
        m_pulse = 0;
        d = key_to_dir(k);
        if (m_dead) begin
            if (k == 8'h2C) model_restart();
        end else if (!m_started) begin
            if (d >= 0) begin
                m_started = 1; m_face = d; m_pend = d; m_frames = 0;
            end
        end else begin
            use_dir = m_pend;
            if (d >= 0 && !is_reverse(d, m_face)) m_pend = d;
            if (frame) begin
                m_frames++;
                if (m_frames == FPS) begin
                    m_frames = 0;
                    nx = m_x + STEP * dx[use_dir];
                    ny = m_y + STEP * dy[use_dir];
                    if (nx >= XMIN && nx <= XMAX && ny >= YMIN && ny <= YMAX) begin
                        m_x = nx; m_y = ny; m_face = use_dir; m_pulse = 1;
                    end else begin
                        m_dead = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic [7:0] k, input logic v, input logic r);
        bus.keycode = k;
        bus.vs      = v;
        rst         = r;
        @(posedge clk);
        model_edge(k, v, r);
        #1;
        chk("x",    32'(bus.snakeX_pos), 32'(m_x));
        chk("y",    32'(bus.snakeY_pos), 32'(m_y));
        chk("face", 32'(bus.motionFlag), 32'(m_face));
        chk("step", 32'(bus.step_pulse), 32'(m_pulse));
        chk("over", 32'(bus.game_over),  32'(m_dead));
        if (bus.step_pulse === 1'b1) pulse_cnt++;
    endtask

    task automatic frame(input logic [7:0] k);
        cyc(k, 1'b1, 1'b0);
        cyc(k, 1'b0, 1'b0);
    endtask

    initial begin
        int p0;
        logic [7:0] k;
        logic v;
        m_vs_prev = 0;
        model_restart();
        bus.keycode = 8'h00;
        bus.vs      = 1'b0;

        // Reset values
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h00, 1'b0, 1'b1);
        chk("rst_x", 32'(bus.snakeX_pos), 32'd300);
        chk("rst_y", 32'(bus.snakeY_pos), 32'd228);
        chk("size",  32'(bus.snake_size), 32'd12);

        // First step right
        pulse_cnt = 0;
        cyc(8'h07, 1'b0, 1'b0);
        repeat (FPS) frame(8'h00);
        chk("t1_x", 32'(bus.snakeX_pos), 32'd324);
        chk("t1_y", 32'(bus.snakeY_pos), 32'd228);
        chk("t1_face", 32'(bus.motionFlag), 32'd3);
        chk("t1_pulses", 32'(pulse_cnt), 32'd1);

        // Reversal to the left is rejected
        cyc(8'h04, 1'b0, 1'b0);
        repeat (FPS) frame(8'h00);
        chk("t2_x", 32'(bus.snakeX_pos), 32'd348);
        chk("t2_face", 32'(bus.motionFlag), 32'd3);

        // Turn up, then 1A held, 04, 16 within one step window
        cyc(8'h1A, 1'b0, 1'b0);
        repeat (FPS) frame(8'h00);
        chk("t3_up_y", 32'(bus.snakeY_pos), 32'd204);
        chk("t3_up_face", 32'(bus.motionFlag), 32'd0);
        repeat (3) frame(8'h1A);
        repeat (2) frame(8'h04);
        repeat (3) frame(8'h16);
        chk("t3_x", 32'(bus.snakeX_pos), 32'd324);
        chk("t3_y", 32'(bus.snakeY_pos), 32'd204);
        chk("t3_face", 32'(bus.motionFlag), 32'd1);

        // Run left into the wall
        cyc(8'h00, 1'b0, 1'b1);
        cyc(8'h04, 1'b0, 1'b0);
        repeat (12 * FPS) frame(8'h00);
        chk("t4_x_edge", 32'(bus.snakeX_pos), 32'd12);
        chk("t4_alive", 32'(bus.game_over), 32'd0);
        p0 = pulse_cnt;
        repeat (FPS) frame(8'h00);
        chk("t4_over", 32'(bus.game_over), 32'd1);
        chk("t4_x_held", 32'(bus.snakeX_pos), 32'd12);
        chk("t4_no_pulse", 32'(pulse_cnt), 32'(p0));
        repeat (FPS) frame(8'h07);
        repeat (FPS) frame(8'h1A);
        chk("t4_dead_x", 32'(bus.snakeX_pos), 32'd12);
        chk("t4_dead_face", 32'(bus.motionFlag), 32'd1);
        chk("t4_dead_over", 32'(bus.game_over), 32'd1);

        // Restart from DEAD; frames alone do not move
        cyc(8'h2C, 1'b0, 1'b0);
        chk("t5_x", 32'(bus.snakeX_pos), 32'd300);
        chk("t5_y", 32'(bus.snakeY_pos), 32'd228);
        chk("t5_face", 32'(bus.motionFlag), 32'd0);
        chk("t5_over", 32'(bus.game_over), 32'd0);
        repeat (2 * FPS) frame(8'h00);
        chk("t5_idle_x", 32'(bus.snakeX_pos), 32'd300);
        chk("t5_idle_y", 32'(bus.snakeY_pos), 32'd228);

        // Reset coinciding with a step frame
        cyc(8'h16, 1'b0, 1'b0);
        repeat (FPS - 1) frame(8'h00);
        cyc(8'h00, 1'b1, 1'b1);
        chk("t6_x", 32'(bus.snakeX_pos), 32'd300);
        chk("t6_y", 32'(bus.snakeY_pos), 32'd228);
        chk("t6_step", 32'(bus.step_pulse), 32'd0);
        chk("t6_face", 32'(bus.motionFlag), 32'd0);
        cyc(8'h00, 1'b0, 1'b0);

        // Randomized traffic against the model
        for (int i = 0; i < 6000; i++) begin
            case ($urandom_range(0, 19))
                0, 1:    k = 8'h1A;
                2, 3:    k = 8'h04;
                4, 5:    k = 8'h16;
                6, 7:    k = 8'h07;
                8:       k = 8'h2C;
                9:       k = 8'($urandom);
                default: k = 8'h00;
            endcase
            v = 1'($urandom_range(0, 1));
            cyc(k, v, ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
